// File: rtl/masked_share_feeder_if.sv
// Operand, reseed and share bus between the masked_share_feeder and its
// neighbours. The master side produces operands and consumes shares; the
// feeder sits on the slave side.
interface masked_share_feeder_if #(
  parameter int WIDTH = 4
);

  // Operand handshake
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;

  // Mask generator reseed
  logic             reseed_en;
  logic [15:0]      reseed_val;

  // Share outputs toward the masked AND gadget
  logic [WIDTH-1:0] x_share0;
  logic [WIDTH-1:0] x_share1;
  logic [WIDTH-1:0] y_share0;
  logic [WIDTH-1:0] y_share1;
  logic [WIDTH-1:0] random;
  logic             shares_valid;
  logic             done;

  modport master (
    output in_valid,
    output x_in,
    output y_in,
    output reseed_en,
    output reseed_val,
    input  in_ready,
    input  x_share0,
    input  x_share1,
    input  y_share0,
    input  y_share1,
    input  random,
    input  shares_valid,
    input  done
  );

  modport slave (
    input  in_valid,
    input  x_in,
    input  y_in,
    input  reseed_en,
    input  reseed_val,
    output in_ready,
    output x_share0,
    output x_share1,
    output y_share0,
    output y_share1,
    output random,
    output shares_valid,
    output done
  );

endinterface

// File: rtl/masked_share_feeder.sv
// Splits unmasked operands X and Y into two Boolean shares each, using fresh
// masks from a 16-bit Galois LFSR, and feeds them to a 2-share masked AND
// gadget. Shares and the refresh mask are held for HOLD_CYCLES cycles, then
// one all-zero precharge (FLUSH) cycle separates consecutive operands so no
// register ever transitions directly between two secrets' shares.
module masked_share_feeder #(
  parameter int          WIDTH       = 4,
  parameter int          HOLD_CYCLES = 2,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  masked_share_feeder_if.slave  bus
);

  // Galois feedback taps for right-shift operation
  localparam logic [15:0] TAPS  = 16'hB400;
  // Hold counter only needs to reach HOLD_CYCLES-1
  localparam int          CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             load_shares;

  logic [15:0]      lfsr;
  logic [15:0]      lfsr_step;
  logic [15:0]      lfsr_next;

  logic [WIDTH-1:0] mx;
  logic [WIDTH-1:0] my;
  logic [WIDTH-1:0] mr;
  logic [WIDTH-1:0] xs0_new;
  logic [WIDTH-1:0] ys0_new;

  logic [WIDTH-1:0] x_share0_reg;
  logic [WIDTH-1:0] x_share1_reg;
  logic [WIDTH-1:0] y_share0_reg;
  logic [WIDTH-1:0] y_share1_reg;
  logic [WIDTH-1:0] random_reg;
  logic             shares_valid_reg;
  logic             done_reg;

  logic             accept;
  logic             unused_lfsr_bits;

  // ---------------------------------------------------------------------------
  // Handshake: ready purely from state, suppressed while reset is asserted
  // ---------------------------------------------------------------------------
  assign bus.in_ready = (state == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // ---------------------------------------------------------------------------
  // Mask generator
  // ---------------------------------------------------------------------------
  assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

  // Reseed wins over the free-running advance; a zero reseed would lock the
  // LFSR, so it falls back to SEED instead.
  always_comb begin
    lfsr_next = lfsr_step;
    if (bus.reseed_en) begin
      lfsr_next = (bus.reseed_val == 16'h0000) ? SEED : bus.reseed_val;
    end
  end

  // LFSR state register, advancing on every non-reset cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_next;
    end
  end

  // Masks are sliced from the pre-advance state of the accept cycle, so a
  // reseed on the accept edge only affects the following operand.
  assign mx = lfsr[WIDTH-1:0];
  assign my = lfsr[2*WIDTH-1:WIDTH];
  assign mr = lfsr[3*WIDTH-1:2*WIDTH];

  // High LFSR bits feed the recurrence only, never a mask
  assign unused_lfsr_bits = ^lfsr[15:3*WIDTH];

  // Per-bit share split: share0 carries the masked value, share1 the mask
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_split
    assign xs0_new[gi] = bus.x_in[gi] ^ mx[gi];
    assign ys0_new[gi] = bus.y_in[gi] ^ my[gi];
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State and hold counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state: accept in IDLE, count HOLD_CYCLES in HOLD, one FLUSH cycle
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    load_shares = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next  = HOLD;
          cnt_next    = '0;
          load_shares = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == CNT_LAST) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      FLUSH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------

  // Shares load on accept, freeze through HOLD, and return to zero otherwise
  // so FLUSH and IDLE present an all-zero precharge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_share0_reg <= '0;
      x_share1_reg <= '0;
      y_share0_reg <= '0;
      y_share1_reg <= '0;
      random_reg   <= '0;
    end else if (load_shares) begin
      x_share0_reg <= xs0_new;
      x_share1_reg <= mx;
      y_share0_reg <= ys0_new;
      y_share1_reg <= my;
      random_reg   <= mr;
    end else if (state_next != HOLD) begin
      x_share0_reg <= '0;
      x_share1_reg <= '0;
      y_share0_reg <= '0;
      y_share1_reg <= '0;
      random_reg   <= '0;
    end
  end

  // Status flags decoded from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      shares_valid_reg <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      shares_valid_reg <= (state_next == HOLD);
      done_reg         <= (state_next == FLUSH);
    end
  end

  assign bus.x_share0     = x_share0_reg;
  assign bus.x_share1     = x_share1_reg;
  assign bus.y_share0     = y_share0_reg;
  assign bus.y_share1     = y_share1_reg;
  assign bus.random       = random_reg;
  assign bus.shares_valid = shares_valid_reg;
  assign bus.done         = done_reg;

endmodule
